// File: rtl/control_unit.sv
// Sequencer for the 4-bit CPU: accepts one opcode per valid/ready handshake and walks a
// Moore FSM that drives the X/Y/Z register commands and the ULA select.
module control_unit (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       valid_i,
  input  logic [2:0] opcode_i,
  output logic       ready_o,
  output logic [3:0] tx_o,
  output logic [3:0] ty_o,
  output logic [3:0] tz_o,
  output logic [1:0] tula_o,
  output logic       done_o,
  output logic [7:0] icount_o
);

  localparam logic [3:0] CmdClear  = 4'd0;
  localparam logic [3:0] CmdLoad   = 4'd1;
  localparam logic [3:0] CmdHold   = 4'd2;
  localparam logic [3:0] CmdShiftR = 4'd3;

  localparam logic [1:0] UlaAdd   = 2'd0;
  localparam logic [1:0] UlaSub   = 2'd1;
  localparam logic [1:0] UlaPassX = 2'd2;

  localparam logic [2:0] OpNop  = 3'd0;
  localparam logic [2:0] OpClr  = 3'd1;
  localparam logic [2:0] OpLdy  = 3'd2;
  localparam logic [2:0] OpAdd  = 3'd3;
  localparam logic [2:0] OpSub  = 3'd4;
  localparam logic [2:0] OpShr  = 3'd5;
  localparam logic [2:0] OpDisp = 3'd6;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StExec  = 3'd2,
    StWrite = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] icount_q, icount_d;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      op_q     <= OpNop;
      icount_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      icount_q <= icount_d;
    end
  end

  // Next state: each opcode enters its sequence at its first active stage.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    icount_d = icount_q;
    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          op_d = opcode_i;
          case (opcode_i)
            OpClr, OpShr:        state_d = StExec;
            OpLdy, OpAdd, OpSub: state_d = StFetch;
            OpDisp:              state_d = StWrite;
            default:             state_d = StDone;
          endcase
        end
      end
      StFetch: state_d = StExec;
      StExec:  state_d = (op_q == OpAdd || op_q == OpSub) ? StWrite : StDone;
      StWrite: state_d = StDone;
      StDone: begin
        state_d  = StIdle;
        icount_d = icount_q + 8'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready_o = 1'b0;
    done_o  = 1'b0;
    tx_o    = CmdHold;
    ty_o    = CmdHold;
    tz_o    = CmdHold;
    tula_o  = UlaAdd;
    unique case (state_q)
      StIdle:  ready_o = 1'b1;
      StFetch: tx_o = CmdLoad;
      StExec: begin
        case (op_q)
          OpClr: begin
            tx_o = CmdClear;
            ty_o = CmdClear;
            tz_o = CmdClear;
          end
          OpLdy: begin
            ty_o   = CmdLoad;
            tula_o = UlaPassX;
          end
          OpAdd: ty_o = CmdLoad;
          OpSub: begin
            ty_o   = CmdLoad;
            tula_o = UlaSub;
          end
          OpShr:   ty_o = CmdShiftR;
          default: ;
        endcase
      end
      StWrite: tz_o = CmdLoad;
      StDone:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign icount_o = icount_q;

endmodule

// File: doc/control_unit.md
# control_unit

Sequencing stage directly upstream of the accumulator register, the X input register and the Z display register of the 4-bit CPU. It accepts one 3-bit instruction at a time through a valid/ready handshake and walks a Moore state machine. The machine drives the per-register command codes (tx, ty, tz) and the ULA select (tula) cycle by cycle. A one-cycle done pulse marks each retired instruction, and a wrapping counter tracks retired instructions.

## Interface
- No parameters. Register command codes are fixed: CLEAR=4'd0, LOAD=4'd1, HOLD=4'd2, SHIFTR=4'd3. ULA codes are fixed: ADD=2'd0, SUB=2'd1, PASSX=2'd2; 2'd3 is unused.
- clock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; forces every register to its reset value immediately.
- valid  in  1  an instruction is presented on opcode.
- opcode  in  3  instruction: 0 NOP, 1 CLR, 2 LDY, 3 ADD, 4 SUB, 5 SHR, 6 DISP, 7 reserved (executes as NOP).
- ready  out  1  high only in IDLE; the block accepts an instruction when valid and ready are both high at a rising edge.
- tx  out  4  command to the X register.
- ty  out  4  command to the accumulator Y.
- tz  out  4  command to the display register Z.
- tula  out  2  ULA operation select.
- done  out  1  one-cycle pulse when an instruction retires.
- icount  out  8  number of retired instructions, modulo 256.

## Operation
- States: IDLE, FETCH, EXEC, WRITE, DONE. The state register and an opcode latch (op_q) are the only control storage besides icount.
- Outputs are Moore-decoded from the state and op_q.
  - Any code not listed for a state is HOLD (tx/ty/tz) or ADD (tula).
  - tula is don't-care for the datapath unless ty=LOAD, but the default value ADD is still required.
- IDLE: ready=1. On valid, latch opcode into op_q and go to the first state of that instruction's sequence.
- Per-instruction sequences (all end in DONE and then IDLE):
  - NOP/7: DONE only.
  - CLR: EXEC with tx=ty=tz=CLEAR.
  - LDY: FETCH with tx=LOAD (X captures the external operand). EXEC with tula=PASSX, ty=LOAD.
  - ADD: FETCH with tx=LOAD. EXEC with tula=ADD, ty=LOAD. WRITE with tz=LOAD (Z captures Y).
  - SUB: same as ADD, but EXEC uses tula=SUB.
  - SHR: EXEC with ty=SHIFTR.
  - DISP: WRITE with tz=LOAD.
- DONE state:
  - done=1, ready=0.
  - icount increments by 1 at the edge leaving DONE; 255 wraps to 0.
- op_q updates only on acceptance. Changes on opcode or valid while ready=0 are ignored, and no queuing occurs.
- Reset values: state IDLE, op_q=0, icount=0. Resulting outputs: ready=1, done=0, tx=ty=tz=HOLD, tula=ADD.

## Timing
- Acceptance edge = edge E0. The first sequence state is active during the cycle after E0.
- Cycles of ready=0 per instruction (acceptance to return to IDLE, inclusive of DONE):
  - 1: NOP, reserved
  - 2: CLR, SHR, DISP
  - 3: LDY
  - 4: ADD, SUB
- Back-to-back: the next instruction can be accepted at the edge ending the first IDLE cycle after DONE. ADD throughput is therefore 5 cycles per instruction.
- done pulse timing:
  - done is high exactly one cycle, 1 to 4 cycles after E0 according to the counts above.
  - done is never high in two consecutive cycles.
- Each register command is asserted for exactly one cycle.
  - The downstream register acts at the edge ending that cycle.
  - FETCH precedes EXEC, so X is stable when the ULA result is loaded into Y.
  - EXEC precedes WRITE, so Z sees the updated Y.
- Reset mid-operation:
  - The block returns to IDLE immediately; the in-flight instruction is abandoned.
  - No done pulse is produced and icount is cleared.
  - All commands are HOLD while reset is high and in the cycle after release.
- valid held high continuously: instructions are accepted on every IDLE edge, and the same opcode repeats.

## Test plan
- Reset then idle: assert reset mid-cycle, no clock -> ready=1, tx=ty=tz=4'd2, tula=0, done=0, icount=0 immediately.
- ADD: valid=1, opcode=3 for one edge -> following cycles show:
  - tx=1
  - ty=1 with tula=0
  - tz=1
  - done=1, ready=0 throughout
  - then IDLE with icount=1
- SHR then CLR back-to-back, valid held high with opcode switched at the IDLE cycle -> SHR: ty=3, done. Then IDLE. Then CLR: tx=ty=tz=0, done. icount=2.
- Handshake: present opcode=4 (SUB), then change opcode to 6 during FETCH -> the EXEC cycle still shows tula=1, and WRITE occurs because the SUB sequence completes. The DISP (6) is accepted only if valid is still high at the next IDLE edge.
- Reset during EXEC of ADD -> outputs return to HOLD immediately, there is no WRITE cycle, and done and icount stay 0.
- Wrap and reserved opcode: 256 NOPs followed by one opcode=7 -> icount reads 0 after the 256th and 1 after the reserved opcode. The reserved opcode produces a single DONE cycle with no command other than HOLD.
